// File: rtl/cache_control_if.sv
`default_nettype none
// ============================================================================
//  Module      : cache_control_if
//  Description : Signal bundle between the L1 cache controller and its
//                surroundings (CPU request side, cache datapath status,
//                physical-memory port and array write strobes).
//                The master side drives requests and status. The slave
//                side is the controller.
//  Revision    : 1.0  initial release
// ============================================================================
interface cache_control_if #(
    parameter int STAT_W = 16
);
    // CPU request side
    logic              mem_read;
    logic              mem_write;
    logic              mem_resp;
    // datapath status
    logic              hit;
    logic              dirty;
    // physical memory port
    logic              pmem_resp;
    logic              pmem_read;
    logic              pmem_write;
    logic              pmem_addr_sel;
    // array control
    logic              data_write;
    logic              data_sel;
    logic              tag_write;
    logic              valid_write;
    logic              dirty_write;
    logic              dirty_in;
    // statistics
    logic [STAT_W-1:0] miss_count;

    modport master (
        output mem_read, mem_write, hit, dirty, pmem_resp,
        input  mem_resp, pmem_read, pmem_write, pmem_addr_sel,
        input  data_write, data_sel, tag_write, valid_write,
        input  dirty_write, dirty_in, miss_count
    );

    modport slave (
        input  mem_read, mem_write, hit, dirty, pmem_resp,
        output mem_resp, pmem_read, pmem_write, pmem_addr_sel,
        output data_write, data_sel, tag_write, valid_write,
        output dirty_write, dirty_in, miss_count
    );
endinterface
`default_nettype wire

// File: rtl/cache_control.sv
`default_nettype none
// ============================================================================
//  Module      : cache_control
//  Description : Control FSM for a direct-mapped 8-set, 128-bit-line L1
//                cache. It answers CPU hits with zero wait states. On a miss
//                it writes back a dirty victim, then fills the line from
//                physical memory and re-checks. It also keeps a saturating
//                miss counter.
//  Revision    : 1.0  initial release
// ============================================================================
module cache_control #(
    parameter int STAT_W = 16
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    cache_control_if.slave  bus
);

    typedef enum logic [1:0] {
        S_CHECK     = 2'd0,
        S_WRITEBACK = 2'd1,
        S_FETCH     = 2'd2
    } state_t;

    localparam logic [STAT_W-1:0] c_CNT_ONE = {{(STAT_W-1){1'b0}}, 1'b1};
    localparam logic [STAT_W-1:0] c_CNT_MAX = {STAT_W{1'b1}};

    state_t            r_state;
    logic [STAT_W-1:0] r_miss_cnt;

    logic w_req;
    logic w_is_write;
    logic w_miss;

    logic w_mem_resp;
    logic w_pmem_read;
    logic w_pmem_write;
    logic w_pmem_addr_sel;
    logic w_data_write;
    logic w_data_sel;
    logic w_tag_write;
    logic w_valid_write;
    logic w_dirty_write;
    logic w_dirty_in;

    // A simultaneous read and write is serviced as a write.
    assign w_req      = bus.mem_read | bus.mem_write;
    assign w_is_write = bus.mem_write;
    assign w_miss     = (r_state == S_CHECK) && w_req && !bus.hit;

    // State register: leave CHECK on a miss; each pmem transfer ends on pmem_resp.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_CHECK;
        end else begin
            case (r_state)
                S_CHECK: begin
                    if (w_miss) begin
                        r_state <= bus.dirty ? S_WRITEBACK : S_FETCH;
                    end
                end
                S_WRITEBACK: begin
                    if (bus.pmem_resp) begin
                        r_state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (bus.pmem_resp) begin
                        r_state <= S_CHECK;
                    end
                end
                default: r_state <= S_CHECK;
            endcase
        end
    end

    // Miss counter: one count per exit from CHECK, saturating at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_miss_cnt <= '0;
        end else if (w_miss && (r_miss_cnt != c_CNT_MAX)) begin
            r_miss_cnt <= r_miss_cnt + c_CNT_ONE;
        end
    end

    // Output decode: combinational from state and inputs, all strobes default low.
    always_comb begin
        w_mem_resp      = 1'b0;
        w_pmem_read     = 1'b0;
        w_pmem_write    = 1'b0;
        w_pmem_addr_sel = 1'b0;
        w_data_write    = 1'b0;
        w_data_sel      = 1'b0;
        w_tag_write     = 1'b0;
        w_valid_write   = 1'b0;
        w_dirty_write   = 1'b0;
        w_dirty_in      = 1'b0;
        case (r_state)
            S_CHECK: begin
                if (w_req && bus.hit) begin
                    w_mem_resp = 1'b1;
                    if (w_is_write) begin
                        // Merge CPU data into the line and mark it dirty.
                        w_data_write  = 1'b1;
                        w_data_sel    = 1'b1;
                        w_dirty_write = 1'b1;
                        w_dirty_in    = 1'b1;
                    end
                end
            end
            S_WRITEBACK: begin
                // The victim line goes out at its stored tag/index address.
                w_pmem_write    = 1'b1;
                w_pmem_addr_sel = 1'b1;
            end
            S_FETCH: begin
                w_pmem_read = 1'b1;
                if (bus.pmem_resp) begin
                    // Install the fetched line as valid and clean.
                    w_data_write  = 1'b1;
                    w_tag_write   = 1'b1;
                    w_valid_write = 1'b1;
                    w_dirty_write = 1'b1;
                end
            end
            default: begin
                w_mem_resp = 1'b0;
            end
        endcase
    end

    assign bus.mem_resp      = w_mem_resp;
    assign bus.pmem_read     = w_pmem_read;
    assign bus.pmem_write    = w_pmem_write;
    assign bus.pmem_addr_sel = w_pmem_addr_sel;
    assign bus.data_write    = w_data_write;
    assign bus.data_sel      = w_data_sel;
    assign bus.tag_write     = w_tag_write;
    assign bus.valid_write   = w_valid_write;
    assign bus.dirty_write   = w_dirty_write;
    assign bus.dirty_in      = w_dirty_in;
    assign bus.miss_count    = r_miss_cnt;

endmodule
`default_nettype wire

// File: tb/tb_cache_control.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cache_control
//  Description : Self-checking bench for cache_control. Two instances run
//                side by side on identical stimulus: one with a 16-bit miss
//                counter and one with a 2-bit miss counter, so saturation is
//                visible. Each stimulus cycle queues its expected outputs.
//                A monitor pops and compares them on the falling edge, or
//                immediately when an asynchronous event is signalled.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cache_control;

    localparam logic [9:0] O_RESP = 10'b10_0000_0000;
    localparam logic [9:0] O_PRD  = 10'b01_0000_0000;
    localparam logic [9:0] O_PWR  = 10'b00_1000_0000;
    localparam logic [9:0] O_SEL  = 10'b00_0100_0000;
    localparam logic [9:0] O_DW   = 10'b00_0010_0000;
    localparam logic [9:0] O_DS   = 10'b00_0001_0000;
    localparam logic [9:0] O_TW   = 10'b00_0000_1000;
    localparam logic [9:0] O_VW   = 10'b00_0000_0100;
    localparam logic [9:0] O_DRW  = 10'b00_0000_0010;
    localparam logic [9:0] O_DIN  = 10'b00_0000_0001;

    localparam logic [9:0] E_NONE   = 10'b0;
    localparam logic [9:0] E_RDHIT  = O_RESP;
    localparam logic [9:0] E_WRHIT  = O_RESP | O_DW | O_DS | O_DRW | O_DIN;
    localparam logic [9:0] E_WB     = O_PWR | O_SEL;
    localparam logic [9:0] E_FETCH  = O_PRD;
    localparam logic [9:0] E_FILL   = O_PRD | O_DW | O_TW | O_VW | O_DRW;

    typedef struct packed {
        logic [9:0]  o;
        logic [15:0] c16;
        logic [1:0]  c2;
    } exp_t;

    logic clk;
    logic rst_n;
    exp_t exp_q[$];
    int   n_cmp;
    int   n_err;
    event ev_async;

    cache_control_if #(.STAT_W(16)) if16 ();
    cache_control_if #(.STAT_W(2))  if2  ();

    cache_control #(.STAT_W(16)) u_dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if16.slave)
    );

    cache_control #(.STAT_W(2)) u_dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic rd, input logic wr, input logic h,
                         input logic d, input logic pr);
        if16.mem_read = rd;  if2.mem_read = rd;
        if16.mem_write = wr; if2.mem_write = wr;
        if16.hit = h;        if2.hit = h;
        if16.dirty = d;      if2.dirty = d;
        if16.pmem_resp = pr; if2.pmem_resp = pr;
    endtask

    // The expected 2-bit count is the hand count clipped at 3.
    task automatic push(input logic [9:0] eo, input int ecnt);
        exp_t e;
        e.o   = eo;
        e.c16 = ecnt[15:0];
        e.c2  = (ecnt > 3) ? 2'd3 : ecnt[1:0];
        exp_q.push_back(e);
    endtask

    task automatic step(input logic rd, input logic wr, input logic h,
                        input logic d, input logic pr,
                        input logic [9:0] eo, input int ecnt);
        @(posedge clk);
        #1;
        drive(rd, wr, h, d, pr);
        push(eo, ecnt);
    endtask

    // Monitor: compare the queued expectation against both DUTs.
    initial begin : monitor
        exp_t       e;
        logic [9:0] a16;
        logic [9:0] a2;
        forever begin
            @(negedge clk or ev_async);
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                a16 = {if16.mem_resp, if16.pmem_read, if16.pmem_write, if16.pmem_addr_sel,
                       if16.data_write, if16.data_sel, if16.tag_write, if16.valid_write,
                       if16.dirty_write, if16.dirty_in};
                a2  = {if2.mem_resp, if2.pmem_read, if2.pmem_write, if2.pmem_addr_sel,
                       if2.data_write, if2.data_sel, if2.tag_write, if2.valid_write,
                       if2.dirty_write, if2.dirty_in};
                n_cmp++;
                if (a16 !== e.o) begin
                    n_err++;
                    $display("FAIL outputs16 @%0t: got %b expected %b", $time, a16, e.o);
                end
                n_cmp++;
                if (if16.miss_count !== e.c16) begin
                    n_err++;
                    $display("FAIL miss_count16 @%0t: got %0d expected %0d",
                             $time, if16.miss_count, e.c16);
                end
                n_cmp++;
                if ({a2, if2.miss_count} !== {e.o, e.c2}) begin
                    n_err++;
                    $display("FAIL outputs2/miss_count2 @%0t: got %b/%0d expected %b/%0d",
                             $time, a2, if2.miss_count, e.o, e.c2);
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1);
    end

    initial begin : stimulus
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset state
        step(0,0,0,0,0, E_NONE, 0);
        step(0,0,0,0,0, E_NONE, 0);
        rst_n = 1'b1;
        step(0,0,0,0,0, E_NONE, 0);

        // Hits: read, write, read+write treated as write
        step(1,0,1,0,0, E_RDHIT, 0);
        step(0,1,1,0,0, E_WRHIT, 0);
        step(1,1,1,1,0, E_WRHIT, 0);
        // hit with no request; stray pmem_resp in CHECK; still in CHECK
        step(0,0,1,1,0, E_NONE, 0);
        step(0,0,0,0,1, E_NONE, 0);
        step(1,0,1,0,0, E_RDHIT, 0);

        // Clean read miss, pmem_resp five cycles after pmem_read first rises
        step(1,0,0,0,0, E_NONE, 0);
        for (int i = 0; i < 5; i++) step(1,0,0,1,0, E_FETCH, 1);
        step(1,0,0,1,1, E_FILL, 1);
        step(1,0,1,0,0, E_RDHIT, 1);
        step(0,0,0,0,0, E_NONE, 1);

        // Dirty write miss: write-back, fetch, fill, write hit
        step(0,1,0,1,0, E_NONE, 1);
        step(0,1,0,1,0, E_WB, 2);
        step(0,1,0,1,0, E_WB, 2);
        step(0,1,0,1,1, E_WB, 2);
        step(0,1,0,1,0, E_FETCH, 2);
        step(0,1,0,1,1, E_FILL, 2);
        step(0,1,1,0,0, E_WRHIT, 2);

        // Request dropped mid-miss: fill completes, no mem_resp, no recount
        step(1,0,0,0,0, E_NONE, 2);
        step(0,0,0,0,0, E_FETCH, 3);
        step(0,0,0,0,1, E_FILL, 3);
        step(0,0,0,0,0, E_NONE, 3);
        step(0,0,1,0,0, E_NONE, 3);

        // Reset asserted mid-FETCH, checked before any clock edge
        step(1,0,0,0,0, E_NONE, 3);
        step(1,0,0,0,0, E_FETCH, 4);
        @(posedge clk);
        #1;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        push(E_NONE, 0);
        -> ev_async;
        step(0,0,0,0,0, E_NONE, 0);
        rst_n = 1'b1;
        step(0,0,0,0,1, E_NONE, 0);
        step(1,0,1,0,0, E_RDHIT, 0);

        // Five back-to-back clean misses: counters 1..5 and 1,2,3,3,3
        for (int m = 1; m <= 5; m++) begin
            step(1,0,0,0,0, E_NONE, m - 1);
            step(1,0,0,0,1, E_FILL, m);
            step(1,0,1,0,0, E_RDHIT, m);
        end

        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
